// File: rtl/div_ctrl_pkg.sv
// Shared definitions for the iterative divider: state encodings, iteration count,
// divide-by-zero quotient and the operand-magnitude helper.
package div_ctrl_pkg;

  localparam int DIV_WIDTH    = 32;
  localparam int DIV_ITER_NUM = 32;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = 32'hFFFF_FFFF;
  localparam logic [4:0]           DIV_LAST_ITER = 5'(DIV_ITER_NUM - 1);

  typedef enum logic [1:0] {
    DIV_STATE_IDLE = 2'd0,
    DIV_STATE_CALC = 2'd1,
    DIV_STATE_SIGN = 2'd2,
    DIV_STATE_DONE = 2'd3
  } div_state_e;

  // Two's-complement magnitude; 0x80000000 maps onto itself, which the
  // unsigned datapath then treats as 2^31.
  function automatic logic [DIV_WIDTH-1:0] div_mag(input logic [DIV_WIDTH-1:0] v,
                                                   input logic               is_signed);
    return (is_signed && v[DIV_WIDTH-1]) ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
// Handshake: a request is taken when start is high while the divider is idle and
// annul is low; stall_req holds the pipeline until done pulses for one cycle with
// result_hi/result_lo valid. annul aborts at any time and no done follows.
interface div_ctrl_if;
  import div_ctrl_pkg::*;

  logic                 start;
  logic                 signed_op;
  logic [DIV_WIDTH-1:0] operand_1;
  logic [DIV_WIDTH-1:0] operand_2;
  logic                 annul;
  logic                 stall_req;
  logic                 done;
  logic [DIV_WIDTH-1:0] result_hi;
  logic [DIV_WIDTH-1:0] result_lo;
  div_state_e           dbg_state;

  modport master (
    output start, signed_op, operand_1, operand_2, annul,
    input  stall_req, done, result_hi, result_lo, dbg_state
  );

  modport slave (
    input  start, signed_op, operand_1, operand_2, annul,
    output stall_req, done, result_hi, result_lo, dbg_state
  );

endinterface

// File: rtl/div_ctrl_step.sv
// One combinational restoring-division iteration: shift {remainder, dividend}
// left by one, trial-subtract the divisor, and shift in the quotient bit.
module div_step
  import div_ctrl_pkg::*;
(
  input  logic [DIV_WIDTH:0]   i_rem,
  input  logic [DIV_WIDTH-1:0] i_shift,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  output logic [DIV_WIDTH:0]   o_rem,
  output logic [DIV_WIDTH-1:0] o_shift
);

  logic [DIV_WIDTH+1:0] w_diff;
  logic [DIV_WIDTH:0]   w_shifted_rem;
  logic                 w_fits;

  // The remainder is always below the divisor, so the shifted value fits in
  // 33 bits; the extra top bit of w_diff is the borrow.
  assign w_shifted_rem = {i_rem[DIV_WIDTH-1:0], i_shift[DIV_WIDTH-1]};
  assign w_diff        = {i_rem, i_shift[DIV_WIDTH-1]} - {2'b00, i_divisor};
  assign w_fits        = ~w_diff[DIV_WIDTH+1];

  assign o_rem   = w_fits ? w_diff[DIV_WIDTH:0] : w_shifted_rem;
  assign o_shift = {i_shift[DIV_WIDTH-2:0], w_fits};

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: IDLE -> CALC (32 restoring steps) -> SIGN -> DONE.
// Build option: define DIV_EARLY_FINISH_EN to skip CALC when |divisor| > |dividend|.
module div_ctrl
  import div_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  div_ctrl_if.slave  io_div
);

  div_state_e           r_state;
  logic [4:0]           r_cnt;
  logic                 r_signed;
  logic                 r_op1_sign;
  logic                 r_op2_sign;
  logic                 r_div_zero;
  logic [DIV_WIDTH-1:0] r_raw_op1;
  logic [DIV_WIDTH-1:0] r_divisor;
  logic [DIV_WIDTH:0]   r_rem;
  logic [DIV_WIDTH-1:0] r_shift;
  logic [DIV_WIDTH-1:0] r_result_hi;
  logic [DIV_WIDTH-1:0] r_result_lo;
  logic                 r_done;

  logic [DIV_WIDTH-1:0] w_op1_mag;
  logic [DIV_WIDTH-1:0] w_op2_mag;
  logic                 w_early;
  logic                 w_accept;
  logic [DIV_WIDTH:0]   w_next_rem;
  logic [DIV_WIDTH-1:0] w_next_shift;
  logic [DIV_WIDTH-1:0] w_rem_lo;

  assign w_op1_mag = div_mag(io_div.operand_1, io_div.signed_op);
  assign w_op2_mag = div_mag(io_div.operand_2, io_div.signed_op);
  assign w_accept  = (r_state == DIV_STATE_IDLE) & io_div.start & ~io_div.annul;
  assign w_rem_lo  = r_rem[DIV_WIDTH-1:0];

`ifdef DIV_EARLY_FINISH_EN
  // Quotient is zero and the remainder is the dividend itself: no steps needed.
  assign w_early = (w_op2_mag != '0) && (w_op2_mag > w_op1_mag);
`else
  assign w_early = 1'b0;
`endif

  div_step u_step (
    .i_rem     (r_rem),
    .i_shift   (r_shift),
    .i_divisor (r_divisor),
    .o_rem     (w_next_rem),
    .o_shift   (w_next_shift)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= DIV_STATE_IDLE;
      r_cnt       <= '0;
      r_signed    <= 1'b0;
      r_op1_sign  <= 1'b0;
      r_op2_sign  <= 1'b0;
      r_div_zero  <= 1'b0;
      r_raw_op1   <= '0;
      r_divisor   <= '0;
      r_rem       <= '0;
      r_shift     <= '0;
      r_result_hi <= '0;
      r_result_lo <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (io_div.annul) begin
        r_state <= DIV_STATE_IDLE;
      end else begin
        unique case (r_state)
          DIV_STATE_IDLE: begin
            if (w_accept) begin
              r_signed   <= io_div.signed_op;
              r_op1_sign <= io_div.operand_1[DIV_WIDTH-1];
              r_op2_sign <= io_div.operand_2[DIV_WIDTH-1];
              r_div_zero <= (io_div.operand_2 == '0);
              r_raw_op1  <= io_div.operand_1;
              r_divisor  <= w_op2_mag;
              r_cnt      <= '0;
              if (w_early) begin
                r_rem   <= {1'b0, w_op1_mag};
                r_shift <= '0;
                r_state <= DIV_STATE_SIGN;
              end else begin
                r_rem   <= '0;
                r_shift <= w_op1_mag;
                r_state <= DIV_STATE_CALC;
              end
            end
          end
          DIV_STATE_CALC: begin
            r_rem   <= w_next_rem;
            r_shift <= w_next_shift;
            r_cnt   <= r_cnt + 5'd1;
            if (r_cnt == DIV_LAST_ITER) begin
              r_state <= DIV_STATE_SIGN;
            end
          end
          DIV_STATE_SIGN: begin
            if (r_div_zero) begin
              r_result_lo <= DIV_ZERO_QUOT;
              r_result_hi <= r_raw_op1;
            end else begin
              // Quotient sign follows the operand signs; remainder follows the dividend.
              r_result_lo <= (r_signed && (r_op1_sign ^ r_op2_sign)) ? (~r_shift + 32'd1) : r_shift;
              r_result_hi <= (r_signed && r_op1_sign) ? (~w_rem_lo + 32'd1) : w_rem_lo;
            end
            r_done  <= 1'b1;
            r_state <= DIV_STATE_DONE;
          end
          DIV_STATE_DONE: begin
            r_state <= DIV_STATE_IDLE;
          end
          default: begin
            r_state <= DIV_STATE_IDLE;
          end
        endcase
      end
    end
  end

  // Low in DONE so the pipeline advances in the cycle that consumes the results.
  assign io_div.stall_req = w_accept
                          | (r_state == DIV_STATE_CALC)
                          | (r_state == DIV_STATE_SIGN);
  assign io_div.done      = r_done;
  assign io_div.result_hi = r_result_hi;
  assign io_div.result_lo = r_result_lo;
  assign io_div.dbg_state = r_state;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed divisions with literal results and
// latencies, then randomized traffic against an arithmetic reference model.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_div (bus)
  );

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

`ifdef DIV_EARLY_FINISH_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (sgn) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic longint unsigned mag(input logic sgn, input logic [31:0] v);
    longint signed s;
    if (sgn) begin
      s = longint'($signed(v));
      return (s < 0) ? longint'(-s) : longint'(s);
    end
    return longint'(v);
  endfunction

  // Edge number (after acceptance) at which results appear.
  function automatic int ref_lat(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    if (EARLY_EN && mag(sgn, b) != 0 && mag(sgn, b) > mag(sgn, a)) return 1;
    return 33;
  endfunction

  int          m_k = -1;
  int          m_l = 33;
  logic [31:0] m_out_hi = '0;
  logic [31:0] m_out_lo = '0;
  logic [31:0] m_pend_hi = '0;
  logic [31:0] m_pend_lo = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_k = -1;
      m_out_hi = '0;
      m_out_lo = '0;
    end else if (bus.annul) begin
      m_k = -1;
    end else if (m_k < 0) begin
      if (bus.start) begin
        {m_pend_hi, m_pend_lo} = ref_div(bus.signed_op, bus.operand_1, bus.operand_2);
        m_l = ref_lat(bus.signed_op, bus.operand_1, bus.operand_2);
        m_k = 0;
      end
    end else begin
      m_k++;
      if (m_k == m_l) begin
        m_out_hi = m_pend_hi;
        m_out_lo = m_pend_lo;
      end else if (m_k == m_l + 1) begin
        m_k = -1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall_req", 32'(bus.stall_req),
          32'(((m_k < 0) && bus.start && !bus.annul) || (m_k >= 0 && m_k < m_l)));
      chk("done", 32'(bus.done), 32'(m_k == m_l));
      chk("result_hi", bus.result_hi, m_out_hi);
      chk("result_lo", bus.result_lo, m_out_lo);
    end
  end

  // ---------------- drivers ----------------
  task automatic drive_idle();
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.operand_1 = '0;
    bus.operand_2 = '0;
    bus.annul     = 1'b0;
  endtask

  task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input int exp_lat);
    int cnt;
    int stall_cnt;
    @(posedge clk);
    #2;
    bus.start     = 1'b1;
    bus.signed_op = sgn;
    bus.operand_1 = a;
    bus.operand_2 = b;
    @(posedge clk);
    #2;
    bus.start     = 1'b0;
    bus.operand_1 = $urandom;
    bus.operand_2 = $urandom;
    bus.signed_op = ~sgn;
    cnt = 0;
    stall_cnt = 0;
    while (cnt < 100) begin
      @(negedge clk);
      if (bus.done) break;
      if (bus.stall_req) stall_cnt++;
      @(posedge clk);
      cnt++;
    end
    chk({name, " done latency"}, 32'(cnt), 32'(exp_lat));
    chk({name, " stall cycles"}, 32'(stall_cnt), 32'(exp_lat));
    chk({name, " result_lo"}, bus.result_lo, exp_lo);
    chk({name, " result_hi"}, bus.result_hi, exp_hi);
    chk({name, " model lo"}, m_out_lo, exp_lo);
    chk({name, " model hi"}, m_out_hi, exp_hi);
    drive_idle();
  endtask

  task automatic rand_operand(output logic [31:0] v, input bit allow_zero);
    case ($urandom_range(0, 7))
      0:       v = allow_zero ? 32'd0 : 32'd1;
      1:       v = 32'(2 ** $urandom_range(0, 31));
      2:       v = 32'h8000_0000;
      3:       v = 32'hFFFF_FFFF;
      4, 5:    v = 32'($urandom_range(1, 200));
      default: v = $urandom;
    endcase
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] b;
    drive_idle();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset stall_req", 32'(bus.stall_req), 32'd0);
    chk("reset result_hi", bus.result_hi, 32'd0);
    chk("reset result_lo", bus.result_lo, 32'd0);
    chk("reset state", 32'(bus.dbg_state), 32'(DIV_STATE_IDLE));
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    chk_en = 1'b1;

    run_div("divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 33);
    run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
    run_div("div ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
    run_div("divu by 0", 1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 33);
    run_div("div by 0", 1'b1, 32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 33);

    // Annul in the 10th CALC cycle, then a clean restart.
    @(posedge clk);
    #2;
    bus.start     = 1'b1;
    bus.operand_1 = 32'd1000;
    bus.operand_2 = 32'd7;
    @(posedge clk);
    #2;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    bus.annul = 1'b1;
    @(posedge clk);
    #2;
    bus.annul = 1'b0;
    @(negedge clk);
    chk("annul stall_req", 32'(bus.stall_req), 32'd0);
    chk("annul done", 32'(bus.done), 32'd0);
    chk("annul result_lo", bus.result_lo, 32'hFFFF_FFFF);
    chk("annul result_hi", bus.result_hi, 32'hDEAD_BEEF);
    chk("annul state", 32'(bus.dbg_state), 32'(DIV_STATE_IDLE));
    repeat (40) @(posedge clk);
    #1;
    chk("annul results held", bus.result_hi, 32'hDEAD_BEEF);
    run_div("divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 33);

    run_div("divu 3/10", 1'b0, 32'd3, 32'd10, 32'd0, 32'd3, EARLY_EN ? 1 : 33);
    run_div("div -3/10", 1'b1, 32'hFFFF_FFFD, 32'd10, 32'd0, 32'hFFFF_FFFD, EARLY_EN ? 1 : 33);

    // Back-to-back: start held high; requests are taken right after each DONE.
    for (int i = 0; i < 120; i++) begin
      @(posedge clk);
      #2;
      bus.start     = 1'b1;
      bus.signed_op = 1'($urandom_range(0, 1));
      rand_operand(a, 1'b0);
      rand_operand(b, 1'b1);
      bus.operand_1 = a;
      bus.operand_2 = b;
    end
    drive_idle();

    // Random traffic including starts while busy and occasional annuls.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      bus.start     = ($urandom_range(0, 3) == 0);
      bus.signed_op = 1'($urandom_range(0, 1));
      rand_operand(a, 1'b0);
      rand_operand(b, 1'b1);
      bus.operand_1 = a;
      bus.operand_2 = b;
      bus.annul     = ($urandom_range(0, 199) == 0);
    end
    drive_idle();
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
